// File: rtl/alu_mul_sequencer.sv
// Multi-cycle unsigned shift-add multiply controller that borrows the shared
// ripple-carry ALU, one partial product per cycle, result left in hi/lo.
module alu_mul_sequencer #(
    parameter int         WIDTH   = 32,
    parameter logic [2:0] SIG_ADD = 3'b010
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             alu_own,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_signal,
    output logic             alu_invert,
    output logic             alu_cin,
    input  logic [WIDTH-1:0] alu_sum,
    input  logic             alu_cout,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] mplr_q, mplr_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             own_q, own_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        mplr_d  = mplr_q;
        mcand_d = mcand_q;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        own_d   = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                // DONE accepts start too, so back-to-back multiplies lose no cycle.
                if (start) begin
                    mcand_d = op_a;
                    acc_d   = '0;
                    mplr_d  = op_b;
                    cnt_d   = '0;
                    state_d = ITER;
                    busy_d  = 1'b1;
                    own_d   = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            ITER: begin
                // The carry becomes the new MSB so the (WIDTH+1)-bit partial sum is never truncated.
                {acc_d, mplr_d} = {alu_cout, alu_sum, mplr_q[WIDTH-1:1]};
                cnt_d           = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end else begin
                    busy_d = 1'b1;
                    own_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            mplr_q  <= '0;
            mcand_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            own_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            mplr_q  <= mplr_d;
            mcand_q <= mcand_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            own_q   <= own_d;
        end
    end

    // ALU drive comes only from registers; the bus is parked at zero when not owned.
    assign alu_own    = own_q;
    assign alu_a      = own_q ? acc_q : '0;
    assign alu_b      = (own_q && mplr_q[0]) ? mcand_q : '0;
    assign alu_signal = own_q ? SIG_ADD : 3'b000;
    assign alu_invert = 1'b0;
    assign alu_cin    = 1'b0;

    assign busy = busy_q;
    assign done = done_q;
    assign hi   = acc_q;
    assign lo   = mplr_q;

endmodule

// File: doc/alu_mul_sequencer.md
# alu_mul_sequencer

Multi-cycle unsigned multiply controller for the EX stage.
- Borrows the shared ripple-carry ALU (the WIDTH-bit array of one-bit ALU slices) and drives its operand, Signal, Invert and CarryIn inputs.
- Performs shift-add multiplication one partial product per cycle and leaves the result in HI/LO.
- While it owns the ALU it asserts `busy`; the hazard unit stalls IF/ID/EX on `busy`, and the EX operand mux selects this block's ALU drive on `alu_own`.

## Interface
Parameters:
- `WIDTH`, 32, operand width; the ALU is WIDTH bits wide.
- `SIG_ADD`, 3'b010, Signal encoding that selects the full-adder output in the slice 4-to-1 mux.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `start`  in  1  request a multiply; sampled on the rising edge.
- `op_a`  in  WIDTH  multiplicand; sampled with an accepted `start`.
- `op_b`  in  WIDTH  multiplier; sampled with an accepted `start`.
- `alu_own`  out  1  this block drives the shared ALU this cycle.
- `alu_a`  out  WIDTH  ALU dataA.
- `alu_b`  out  WIDTH  ALU dataB.
- `alu_signal`  out  3  ALU Signal.
- `alu_invert`  out  1  ALU Invert.
- `alu_cin`  out  1  ALU CarryIn of bit 0.
- `alu_sum`  in  WIDTH  ALU result, combinational from the alu_* outputs.
- `alu_cout`  in  1  carry out of the MSB slice.
- `busy`  out  1  multiply in progress.
- `done`  out  1  one-cycle pulse; `hi`/`lo` are valid.
- `hi`  out  WIDTH  upper product half.
- `lo`  out  WIDTH  lower product half.

## Operation
State machine: IDLE, ITER, DONE.
- IDLE: `busy`=0, `alu_own`=0.
  - On `start`=1: load mcand←op_a, {acc,mplr}←{0,op_b}, cnt←0, go to ITER.
- ITER: `busy`=1, `alu_own`=1.
  - ALU drive: `alu_a`=acc, `alu_b`=mplr[0] ? mcand : 0, `alu_signal`=SIG_ADD, `alu_invert`=0, `alu_cin`=0.
  - Each edge: {acc,mplr} ← {alu_cout, alu_sum, mplr[WIDTH-1:1]}, shifted right one bit overall, i.e. the 2·WIDTH+1-bit value {cout,sum,mplr} >> 1.
  - cnt increments; after WIDTH iterations (cnt = WIDTH-1 on the edge), go to DONE.
- DONE: `done`=1, `busy`=0, `alu_own`=0.
  - `hi`=acc and `lo`=mplr, registered.
  - Next state is ITER if `start`=1, otherwise IDLE.

Output rules:
- `hi`/`lo` are the acc/mplr registers. They hold the last product until the next accepted start, then change every ITER cycle. Consumers read them only on `done` or while `busy`=0.
- When `alu_own`=0: `alu_a`, `alu_b`, `alu_signal`, `alu_invert` and `alu_cin` drive 0.
- Result = op_a × op_b unsigned, full 2·WIDTH bits; no overflow is possible.
- Arithmetic: the WIDTH-bit sum plus `alu_cout` forms a WIDTH+1-bit value. The carry is never dropped.

## Timing
- Reset (async, `rst_n`=0): state=IDLE, cnt=0, acc=mplr=mcand=0. `busy`=0, `done`=0, `alu_own`=0, `hi`=`lo`=0, all alu_* outputs=0. Takes effect immediately, without a clock.
- Reset mid-ITER aborts the multiply; no `done` is produced. After `rst_n` rises, the first edge with `start`=1 is accepted.
- Latency: `start` accepted at edge k gives `busy`=1 from k to k+WIDTH, `done`=1 in the cycle after edge k+WIDTH. That is WIDTH+1 edges from start to `done`.
- `start` is accepted in IDLE or DONE, so back-to-back multiplies lose no cycle. `start` is ignored while in ITER; operands are not re-sampled.
- `done` is high for exactly one cycle per completed multiply.
- `busy` and `done` are never high together.
- The ALU path is combinational within a cycle: alu_* outputs come from registers only, and `alu_sum`/`alu_cout` are consumed at the same edge.

## Test plan
- Reset: hold `rst_n`=0 mid-run at ITER cnt=10 → `busy`, `done`, `alu_own`, `hi` and `lo` all 0 immediately. Release and start 3×5 → `done` 33 cycles later, `hi`=0, `lo`=15.
- Max operands: op_a=op_b=32'hFFFF_FFFF → `hi`=32'hFFFF_FFFE, `lo`=32'h0000_0001. Exercises `alu_cout` capture every iteration.
- Zero and identity:
  - 0×32'hDEAD_BEEF → `hi`=`lo`=0.
  - 1×32'h8000_0000 → `hi`=0, `lo`=32'h8000_0000.
  - `alu_b`=0 on every cycle where mplr[0]=0.
- Back-to-back: assert `start` in the DONE cycle with 32'h1_0000×32'h1_0000. Then `busy` rises on the next edge, and the second `done` gives `hi`=1, `lo`=0. A `start` pulsed mid-ITER is ignored and the result is unchanged.
- ALU drive check: during ITER, `alu_signal`=3'b010, `alu_invert`=0, `alu_cin`=0, `alu_own`=1. In IDLE and DONE all alu_* outputs=0. `busy` is high for exactly 32 cycles per multiply.
- Random: 1000 random operand pairs with a random `start` gap of 0..3 cycles → {hi,lo} equals the 64-bit unsigned reference product on each `done`.
